// File: rtl/pseudo_softmax_normalizer_if.sv
// Handshake bundle: one vector-in stream (ten scores plus sum exponent/mantissa)
// and one element-out stream of Q0.8 pseudo-probabilities.
interface pseudo_softmax_normalizer_if;
    logic [7:0] x1, x2, x3, x4, x5, x6, x7, x8, x9, x10;
    logic [8:0] exp;
    logic [7:0] mant;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_idx;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, exp, mant, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_last, out_valid
    );

    modport slave (
        input  x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, exp, mant, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_last, out_valid
    );
endinterface

// File: rtl/pseudo_softmax_normalizer.sv
// Captures a score vector and streams p_i ~ 2^x_i / sum in Q0.8, one element per handshake.
// Latency 2 cycles accept-to-first-element; outputs hold while out_ready is low, in_ready low while busy.
module pseudo_softmax_normalizer #(
    parameter int N   = 10,
    parameter int SAT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    pseudo_softmax_normalizer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    localparam logic [7:0] SAT_V  = 8'(SAT);
    localparam logic [3:0] LAST_I = 4'(N - 1);

    state_t     state_q, state_d;
    logic [7:0] x_q [N];
    logic [8:0] exp_q;
    logic [7:0] mant_q;
    logic [7:0] out_data_q, out_data_d;
    logic [3:0] out_idx_q, out_idx_d;
    logic       out_last_q, out_last_d;
    logic       out_valid_q, out_valid_d;
    logic       cap_en;

    logic [7:0]        in_x [N];
    logic [3:0]        elem_idx;
    logic [7:0]        x_sel;
    logic signed [9:0] d_raw;
    logic [9:0]        d_cl, s, r, p;
    logic [7:0]        elem_data;

    assign in_x[0] = bus.x1;
    assign in_x[1] = bus.x2;
    assign in_x[2] = bus.x3;
    assign in_x[3] = bus.x4;
    assign in_x[4] = bus.x5;
    assign in_x[5] = bus.x6;
    assign in_x[6] = bus.x7;
    assign in_x[7] = bus.x8;
    assign in_x[8] = bus.x9;
    assign in_x[9] = bus.x10;

    // Division replaced by exponent difference, linear reciprocal 1-f/2 and a right shift.
    always_comb begin
        elem_idx = (state_q == LOAD) ? 4'd0 : out_idx_q + 4'd1;
        x_sel    = 8'd0;
        for (int i = 0; i < N; i++) begin
            if (elem_idx == 4'(i)) x_sel = x_q[i];
        end
        d_raw     = $signed({1'b0, exp_q}) - $signed({2'b00, x_sel});
        d_cl      = d_raw[9] ? 10'd0 : d_raw;
        s         = d_cl + 10'd1;
        r         = 10'd512 - {2'b00, mant_q};
        p         = (s >= 10'd10) ? 10'd0 : (r >> s);
        elem_data = (p == 10'd256) ? SAT_V : p[7:0];
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        cap_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cap_en  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                out_data_d  = elem_data;
                out_idx_d   = 4'd0;
                out_last_d  = (LAST_I == 4'd0);
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (out_idx_q == LAST_I) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        out_data_d = elem_data;
                        out_idx_d  = elem_idx;
                        out_last_d = (elem_idx == LAST_I);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_data_q  <= 8'd0;
            out_idx_q   <= 4'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            exp_q       <= 9'd0;
            mant_q      <= 8'd0;
            for (int i = 0; i < N; i++) x_q[i] <= 8'd0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            if (cap_en) begin
                exp_q  <= bus.exp;
                mant_q <= bus.mant;
                for (int i = 0; i < N; i++) x_q[i] <= in_x[i];
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_pseudo_softmax_normalizer.sv
module tb_pseudo_softmax_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pseudo_softmax_normalizer_if bus ();

    pseudo_softmax_normalizer #(.N(10), .SAT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    bit          bp_mode = 1'b0;
    logic [12:0] sb [$];   // {last, idx, data}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] e [10]);
        for (int i = 0; i < 10; i++) sb.push_back({(i == 9), 4'(i), e[i]});
    endtask

    task automatic set_inputs(input logic [7:0] xv [10], input logic [8:0] ex, input logic [7:0] mn);
        bus.x1 = xv[0]; bus.x2 = xv[1]; bus.x3 = xv[2]; bus.x4 = xv[3]; bus.x5 = xv[4];
        bus.x6 = xv[5]; bus.x7 = xv[6]; bus.x8 = xv[7]; bus.x9 = xv[8]; bus.x10 = xv[9];
        bus.exp = ex;
        bus.mant = mn;
    endtask

    task automatic scramble();
        logic [7:0] rv [10];
        for (int i = 0; i < 10; i++) rv[i] = 8'($urandom);
        set_inputs(rv, 9'($urandom), 8'($urandom));
        bus.in_valid = 1'b1;
    endtask

    task automatic send_vec(input logic [7:0] xv [10], input logic [8:0] ex, input logic [7:0] mn,
                            input logic [7:0] e [10], input bit hold);
        int n;
        @(posedge clk); #1;
        set_inputs(xv, ex, mn);
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        push_exp(e);
        @(posedge clk); #1;
        if (hold) scramble();
        else bus.in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_T1", bus.in_ready, 0);
        chk("out_valid_T1", bus.out_valid, 0);
        @(posedge clk); #1;
        if (hold) scramble();
        @(negedge clk);
        chk("out_valid_T2", bus.out_valid, 1);
    endtask

    task automatic drain(input bit hold);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !bus.out_valid) begin
                bus.in_valid = 1'b0;
                done = 1'b1;
            end else if (hold) begin
                scramble();
            end
        end
        bus.in_valid = 1'b0;
        if (!done) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
        chk("in_ready_after_last", bus.in_ready, 1);
        chk("sb_empty", sb.size(), 0);
    endtask

    // Monitor: compares the presented element against the scoreboard head; pops on handshake.
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                chk("in_ready_busy", bus.in_ready, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb[0];
                    chk("out_idx", bus.out_idx, e[11:8]);
                    chk("out_data", bus.out_data, e[7:0]);
                    chk("out_last", bus.out_last, e[12]);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    // out_ready pattern 1,0,0 repeating when back-pressure is enabled.
    initial begin
        int k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                bus.out_ready = (k % 3 == 0);
                k++;
            end else begin
                bus.out_ready = 1'b1;
                k = 0;
            end
        end
    end

    initial begin
        logic [7:0] xa [10];
        logic [7:0] xb [10];
        logic [7:0] xc [10];
        logic [7:0] xd [10];
        logic [7:0] ea [10];
        logic [7:0] eb [10];
        logic [7:0] ec [10];
        logic [7:0] ed [10];
        int target, n;

        xa = '{5, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        ea = '{255, 64, 8, 8, 8, 8, 8, 8, 8, 8};
        xb = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        eb = '{192, 192, 192, 192, 192, 192, 192, 192, 192, 192};
        xc = '{12, 11, 25, 0, 0, 0, 0, 0, 0, 0};
        ec = '{1, 0, 255, 0, 0, 0, 0, 0, 0, 0};
        xd = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        ed = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255};

        bus.in_valid = 1'b1;
        set_inputs(xa, 9'd5, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);

        send_vec(xa, 9'd5, 8'd0, ea, 1'b0);
        drain(1'b0);
        send_vec(xb, 9'd4, 8'd128, eb, 1'b0);
        drain(1'b0);
        send_vec(xc, 9'd20, 8'd0, ec, 1'b0);
        drain(1'b0);

        bp_mode = 1'b1;
        target = hs_cnt + 10;
        send_vec(xa, 9'd5, 8'd0, ea, 1'b0);
        drain(1'b0);
        chk("bp_handshakes", hs_cnt, target);
        bp_mode = 1'b0;

        target = hs_cnt + 4;
        send_vec(xb, 9'd4, 8'd128, eb, 1'b0);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (hs_cnt < target && n < 100);
        if (hs_cnt < target) chk("abort_wait_timeout", hs_cnt, target);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        send_vec(xd, 9'd5, 8'd0, ed, 1'b0);
        drain(1'b0);

        send_vec(xc, 9'd20, 8'd0, ec, 1'b1);
        drain(1'b1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
